axis_route_arbiter: RTL and testbench

AXIS_ROUTE_ARBITER -- requirements
Module: axis_route_arbiter

---
 rtl/axis_route_arbiter.sv | 145 ++++++++++++++
 tb/tb_axis_route_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_route_arbiter.sv
// axis_route_arbiter: per-destination round-robin packet arbiter for a vFPGA AXIS switch.
// Each source latches a route word while disconnected; each destination locks one source
// from grant until its tlast handshake, then rotates priority past that source.
// Optional per-destination packet counters are built when SWITCH_STATS_EN is defined.
module axis_route_arbiter #(
  parameter int unsigned N_REGIONS = 4,
  parameter int unsigned N_ID      = N_REGIONS,
  parameter int unsigned N_ID_BITS = (N_ID > 1) ? $clog2(N_ID) : 1
) (
  input  logic                               aclk,
  input  logic                               aresetn,
  input  logic [N_REGIONS-1:0][7:0]          io_ctrl,
  input  logic [N_ID-1:0]                    src_tvalid,
  input  logic [N_ID-1:0]                    src_tlast,
  input  logic [N_ID-1:0]                    src_tready,
  output logic [N_ID-1:0]                    gnt_pass,
  output logic [N_ID-1:0][N_ID_BITS-1:0]     gnt_tdest,
  output logic [N_ID-1:0]                    route_err,
  output logic [N_ID-1:0][31:0]              stat_pkt_cnt
);

  localparam int unsigned DEST_W = 4;
  localparam int unsigned CNT_W  = 32;

  typedef enum logic {ST_IDLE = 1'b0, ST_LOCK = 1'b1} state_t;

  state_t               state_q      [N_ID];
  logic [N_ID_BITS-1:0] owner_q      [N_ID];
  logic [N_ID_BITS-1:0] rr_q         [N_ID];
  logic [N_ID-1:0]      route_en_q;
  logic [DEST_W-1:0]    route_dest_q [N_ID];

  logic [N_ID-1:0]      route_ok;
  logic [N_ID-1:0]      req          [N_ID];
  logic [N_ID-1:0]      grant_any;
  logic [N_ID-1:0]      release_d;
  logic [N_ID-1:0]      grant_src;
  logic [N_ID-1:0]      release_src;
  logic [N_ID-1:0]      pass_next;
  logic [N_ID_BITS-1:0] grant_idx    [N_ID];
  logic [N_ID_BITS-1:0] rr_next      [N_ID];
  logic [N_ID_BITS-1:0] sel;

  // Only enable and dest are meaningful; the spare route-word bits are intentionally ignored.
  logic unused_ctrl_bits;
  assign unused_ctrl_bits = ^io_ctrl;

  // Route validity and per-destination request vectors from the latched routes.
  always_comb begin
    route_ok = '0;
    for (int d = 0; d < N_ID; d++) req[d] = '0;
    for (int i = 0; i < N_ID; i++) begin
      route_ok[i] = route_en_q[i]
                 && ({1'b0, route_dest_q[i]} < 5'(N_ID))
                 && (route_dest_q[i] != DEST_W'(i));
    end
    for (int d = 0; d < N_ID; d++) begin
      for (int i = 0; i < N_ID; i++) begin
        req[d][i] = src_tvalid[i] && route_ok[i] && (route_dest_q[i] == DEST_W'(d));
      end
    end
  end

  // Grant search from rr upward in IDLE, release on the owner's tlast handshake in LOCK.
  always_comb begin
    grant_any   = '0;
    release_d   = '0;
    grant_src   = '0;
    release_src = '0;
    sel         = '0;
    for (int d = 0; d < N_ID; d++) begin
      grant_idx[d] = '0;
      rr_next[d]   = rr_q[d];
    end
    for (int d = 0; d < N_ID; d++) begin
      if (state_q[d] == ST_IDLE) begin
        for (int k = 0; k < N_ID; k++) begin
          sel = N_ID_BITS'((32'(rr_q[d]) + 32'(k)) % N_ID);
          if (!grant_any[d] && req[d][sel]) begin
            grant_any[d]   = 1'b1;
            grant_idx[d]   = sel;
            grant_src[sel] = 1'b1;
          end
        end
      end else if (src_tvalid[owner_q[d]] && src_tready[owner_q[d]] && src_tlast[owner_q[d]]) begin
        release_d[d]            = 1'b1;
        release_src[owner_q[d]] = 1'b1;
        rr_next[d]              = N_ID_BITS'((32'(owner_q[d]) + 32'd1) % N_ID);
      end
    end
    pass_next = (gnt_pass & ~release_src) | grant_src;
  end

  // Destination FSMs, route registers and registered grant/error outputs.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      for (int d = 0; d < N_ID; d++) begin
        state_q[d] <= ST_IDLE;
        owner_q[d] <= '0;
        rr_q[d]    <= '0;
      end
      for (int i = 0; i < N_ID; i++) route_dest_q[i] <= '0;
      route_en_q <= '0;
      gnt_pass   <= '0;
      gnt_tdest  <= '0;
      route_err  <= '0;
    end else begin
      for (int d = 0; d < N_ID; d++) begin
        if (grant_any[d]) begin
          state_q[d] <= ST_LOCK;
          owner_q[d] <= grant_idx[d];
        end else if (release_d[d]) begin
          state_q[d] <= ST_IDLE;
          rr_q[d]    <= rr_next[d];
        end
      end
      for (int i = 0; i < N_ID; i++) begin
        // A route is frozen from grant until release, so changes land on packet boundaries.
        if (!pass_next[i]) begin
          route_en_q[i]   <= io_ctrl[i][7];
          route_dest_q[i] <= io_ctrl[i][3:0];
        end
        gnt_tdest[i] <= pass_next[i] ? N_ID_BITS'(route_dest_q[i]) : '0;
        route_err[i] <= src_tvalid[i] && !route_ok[i];
      end
      gnt_pass <= pass_next;
    end
  end

`ifdef SWITCH_STATS_EN
  // Delivered-packet counters, one per destination, wrapping naturally.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      stat_pkt_cnt <= '0;
    end else begin
      for (int d = 0; d < N_ID; d++) begin
        if (release_d[d]) stat_pkt_cnt[d] <= stat_pkt_cnt[d] + CNT_W'(1);
      end
    end
  end
`else
  assign stat_pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_axis_route_arbiter.sv
// Bench for axis_route_arbiter: directed scenarios plus randomized traffic checked each
// cycle against a behavioural model of per-destination packet ownership.
module tb_axis_route_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned NB = 2;

  logic                  aclk = 1'b0;
  logic                  aresetn;
  logic [N-1:0][7:0]     io_ctrl;
  logic [N-1:0]          src_tvalid, src_tlast, src_tready;
  logic [N-1:0]          gnt_pass;
  logic [N-1:0][NB-1:0]  gnt_tdest;
  logic [N-1:0]          route_err;
  logic [N-1:0][31:0]    stat_pkt_cnt;

  always #5 aclk = ~aclk;

  axis_route_arbiter #(.N_REGIONS(N), .N_ID(N), .N_ID_BITS(NB)) dut (
    .aclk(aclk), .aresetn(aresetn), .io_ctrl(io_ctrl),
    .src_tvalid(src_tvalid), .src_tlast(src_tlast), .src_tready(src_tready),
    .gnt_pass(gnt_pass), .gnt_tdest(gnt_tdest), .route_err(route_err),
    .stat_pkt_cnt(stat_pkt_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: latched route per source, and per destination who (if anyone) holds it.
  int          m_en [N];
  int          m_dest [N];
  int          m_busy [N];
  int          m_owner [N];
  int          m_rr [N];
  logic [31:0] m_cnt [N];
  logic [N-1:0] m_err;

`ifdef SWITCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit m_valid(input int i);
    return (m_en[i] != 0) && (m_dest[i] < N) && (m_dest[i] != i);
  endfunction

  task automatic model_edge();
    logic [N-1:0] err_n;
    bit found;
    int s, o;
    if (!aresetn) begin
      for (int i = 0; i < N; i++) begin
        m_en[i] = 0; m_dest[i] = 0; m_busy[i] = 0; m_owner[i] = 0; m_rr[i] = 0; m_cnt[i] = 0;
      end
      m_err = '0;
    end else begin
      for (int i = 0; i < N; i++) err_n[i] = src_tvalid[i] && !m_valid(i);
      for (int d = 0; d < N; d++) begin
        if (m_busy[d] != 0) begin
          o = m_owner[d];
          if (src_tvalid[o] && src_tready[o] && src_tlast[o]) begin
            m_busy[d] = 0;
            m_rr[d]   = (o + 1) % N;
            m_cnt[d]  = m_cnt[d] + 32'd1;
          end
        end else begin
          found = 1'b0;
          for (int k = 0; k < N; k++) begin
            s = (m_rr[d] + k) % N;
            if (!found && src_tvalid[s] && m_valid(s) && m_dest[s] == d) begin
              found = 1'b1; m_busy[d] = 1; m_owner[d] = s;
            end
          end
        end
      end
      m_err = err_n;
      // Disconnected sources pick up the current route word.
      for (int i = 0; i < N; i++) begin
        found = 1'b0;
        for (int d = 0; d < N; d++) if (m_busy[d] != 0 && m_owner[d] == i) found = 1'b1;
        if (!found) begin
          m_en[i]   = io_ctrl[i][7] ? 1 : 0;
          m_dest[i] = int'(io_ctrl[i][3:0]);
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [N-1:0]  e_pass;
    logic [NB-1:0] e_tdest [N];
    e_pass = '0;
    for (int i = 0; i < N; i++) e_tdest[i] = '0;
    for (int d = 0; d < N; d++) begin
      if (m_busy[d] != 0) begin
        e_pass[m_owner[d]]  = 1'b1;
        e_tdest[m_owner[d]] = NB'(d);
      end
    end
    check("gnt_pass", 64'(gnt_pass), 64'(e_pass));
    check("route_err", 64'(route_err), 64'(m_err));
    for (int i = 0; i < N; i++)
      check($sformatf("gnt_tdest[%0d]", i), 64'(gnt_tdest[i]), 64'(e_tdest[i]));
    for (int d = 0; d < N; d++)
      check($sformatf("stat_pkt_cnt[%0d]", d), 64'(stat_pkt_cnt[d]), STATS ? 64'(m_cnt[d]) : 64'd0);
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
    model_edge();
    compare_all();
  endtask

  int  order_q[$];
  int  gap, npk, own, waits;
  bit  prev_pass, got;

  initial begin
    aresetn = 1'b0; io_ctrl = '0;
    src_tvalid = '0; src_tlast = '0; src_tready = '0;
    for (int i = 0; i < N; i++) begin
      m_en[i] = 0; m_dest[i] = 0; m_busy[i] = 0; m_owner[i] = 0; m_rr[i] = 0; m_cnt[i] = 0;
    end
    m_err = '0;

    // Reset state
    step(); step();
    check("rst_pass", 64'(gnt_pass), 64'd0);
    check("rst_err", 64'(route_err), 64'd0);
    check("rst_tdest", 64'(gnt_tdest), 64'd0);
    check("rst_stat0", 64'(stat_pkt_cnt[0]), 64'd0);
    aresetn = 1'b1;

    // Single 4-beat packet 0->1, route word changed to dest 2 during beat 2
    io_ctrl[0] = 8'h81;
    step(); step();
    src_tvalid[0] = 1'b1; src_tready = '1; src_tlast = '0;
    step();
    check("pkt_grant_latency", 64'(gnt_pass[0]), 64'd1);
    check("pkt_tdest_b1", 64'(gnt_tdest[0]), 64'd1);
    step();
    io_ctrl[0] = 8'h82;
    step();
    check("pkt_tdest_b3", 64'(gnt_tdest[0]), 64'd1);
    step();
    check("pkt_tdest_b4", 64'(gnt_tdest[0]), 64'd1);
    src_tlast[0] = 1'b1;
    step();
    check("pkt_pass_falls", 64'(gnt_pass[0]), 64'd0);
    src_tlast[0] = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 5 && !got; k++) begin
      step();
      got = gnt_pass[0];
    end
    check("next_pkt_granted", 64'(got), 64'd1);
    check("next_pkt_tdest", 64'(gnt_tdest[0]), 64'd2);
    src_tlast[0] = 1'b1;
    step();
    src_tvalid = '0; src_tlast = '0; io_ctrl = '0;
    step();

    // Round-robin: 0, 2, 3 all to destination 1, starting from a fresh reset
    aresetn = 1'b0; step(); aresetn = 1'b1;
    io_ctrl[0] = 8'h81; io_ctrl[2] = 8'h81; io_ctrl[3] = 8'h81;
    src_tvalid = 4'b1101; src_tlast = '1; src_tready = '1;
    prev_pass = 1'b0; gap = 0;
    for (int k = 0; k < 30 && order_q.size() < 4; k++) begin
      step();
      if (gnt_pass != '0) begin
        own = 0;
        for (int i = 0; i < N; i++) if (gnt_pass[i]) own = i;
        if (!prev_pass) begin
          if (order_q.size() > 0) check("rr_idle_gap", 64'(gap), 64'd1);
          order_q.push_back(own);
        end
        gap = 0; prev_pass = 1'b1;
      end else begin
        gap++; prev_pass = 1'b0;
      end
    end
    check("rr_count", 64'(order_q.size()), 64'd4);
    while (order_q.size() < 4) order_q.push_back(-1);
    check("rr_order0", 64'(order_q[0]), 64'd0);
    check("rr_order1", 64'(order_q[1]), 64'd2);
    check("rr_order2", 64'(order_q[2]), 64'd3);
    check("rr_order3", 64'(order_q[3]), 64'd0);
    src_tvalid = '0; src_tlast = '0;
    step(); step();
    io_ctrl = '0;
    step();

    // Invalid routes: disabled, then self-targeted
    io_ctrl[1] = 8'h01;
    step();
    src_tvalid[1] = 1'b1;
    step();
    check("err_disabled", 64'(route_err[1]), 64'd1);
    check("err_disabled_nogrant", 64'(gnt_pass[1]), 64'd0);
    io_ctrl[1] = 8'h81;
    step(); step();
    check("err_self", 64'(route_err[1]), 64'd1);
    check("err_self_nogrant", 64'(gnt_pass[1]), 64'd0);
    src_tvalid = '0; io_ctrl = '0;
    step();

    // Reset in beat 3, then three packets into destination 0
    io_ctrl[1] = 8'h80; src_tready = '1; src_tlast = '0;
    step();
    src_tvalid[1] = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 4 && !got; k++) begin
      step();
      got = gnt_pass[1];
    end
    check("midpkt_granted", 64'(got), 64'd1);
    step(); step();
    aresetn = 1'b0;
    step();
    check("midpkt_rst_pass", 64'(gnt_pass), 64'd0);
    check("midpkt_rst_stat0", 64'(stat_pkt_cnt[0]), 64'd0);
    aresetn = 1'b1; src_tlast[1] = 1'b1;
    npk = 0; waits = 0;
    while (npk < 3 && waits < 30) begin
      step();
      waits++;
      if (gnt_pass[1]) begin
        npk++;
        if (npk == 3) step();
      end
    end
    src_tvalid = '0; src_tlast = '0;
    check("three_pkts_seen", 64'(npk), 64'd3);
    step();
    check("stat_three", 64'(stat_pkt_cnt[0]), STATS ? 64'd3 : 64'd0);
    io_ctrl = '0;

    // Randomized traffic
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        own = $urandom_range(0, N - 1);
        io_ctrl[own] = {($urandom_range(0, 99) < 85) ? 1'b1 : 1'b0, 3'($urandom), 4'($urandom_range(0, 5))};
      end
      for (int i = 0; i < N; i++) begin
        src_tvalid[i] = ($urandom_range(0, 99) < 70);
        src_tready[i] = ($urandom_range(0, 99) < 75);
        src_tlast[i]  = ($urandom_range(0, 99) < 30);
      end
      aresetn = ($urandom_range(0, 199) != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
